// File: rtl/iob_split_tmo.sv
// iob_split_tmo: routes one IOb native master request to one of N_SLAVES
// slave ports. The slave is chosen by the address field
// m_addr[P_SLAVES -: SEL_W].
// Request fields are captured into registers before they go to the slaves.
// A selector value with no matching slave gets an error response.
// A slave that stays silent for TIMEOUT BUSY cycles is aborted.
// Both error kinds set a sticky flag that err_clr_i clears.
module iob_split_tmo #(
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter int               N_SLAVES = 4,
  parameter int               P_SLAVES = ADDR_W - 2,
  parameter int               SEL_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
  parameter int               TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           m_valid_i,
  input  logic [ADDR_W-1:0]              m_addr_i,
  input  logic [DATA_W-1:0]              m_wdata_i,
  input  logic [DATA_W/8-1:0]            m_wstrb_i,
  output logic [DATA_W-1:0]              m_rdata_o,
  output logic                           m_ready_o,
  output logic [N_SLAVES-1:0]            s_valid_o,
  output logic [N_SLAVES*ADDR_W-1:0]     s_addr_o,
  output logic [N_SLAVES*DATA_W-1:0]     s_wdata_o,
  output logic [N_SLAVES*(DATA_W/8)-1:0] s_wstrb_o,
  input  logic [N_SLAVES*DATA_W-1:0]     s_rdata_i,
  input  logic [N_SLAVES-1:0]            s_ready_i,
  output logic                           err_o,
  output logic [1:0]                     err_cause_o,
  input  logic                           err_clr_i
);

  localparam int          STRB_W     = DATA_W / 8;
  localparam int          CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] N_SLAVES_L = 32'(N_SLAVES);
  // TMO_LAST is only used when TIMEOUT != 0.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [SEL_W-1:0]    sel_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [N_SLAVES-1:0] s_valid_q;
  logic [DATA_W-1:0]   m_rdata_q;
  logic                m_ready_q;
  logic                err_q;
  logic [1:0]          err_cause_q;

  logic [SEL_W-1:0]    sel_d;
  logic                mapped_d;
  logic [N_SLAVES-1:0] onehot_d;
  logic [DATA_W-1:0]   rdata_sel_d;
  logic                ready_sel_d;

  assign sel_d    = m_addr_i[P_SLAVES -: SEL_W];
  assign mapped_d = ({{(32-SEL_W){1'b0}}, sel_d} < N_SLAVES_L);

  // Only the qualified lane can complete. This masks ready from the other
  // lanes, and also a late ready from a slave that was aborted.
  assign ready_sel_d = |(s_ready_i & s_valid_q);

  // Decode the incoming selector to one-hot and mux the selected lane's rdata.
  always_comb begin
    onehot_d    = '0;
    rdata_sel_d = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      onehot_d[i] = (sel_d == SEL_W'(i));
      rdata_sel_d = rdata_sel_d |
                    ({DATA_W{sel_q == SEL_W'(i)}} & s_rdata_i[i*DATA_W +: DATA_W]);
    end
  end

  // Transaction FSM. All master, slave and status outputs are registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      s_valid_q   <= '0;
      m_rdata_q   <= '0;
      m_ready_q   <= 1'b0;
      err_q       <= 1'b0;
      err_cause_q <= 2'b00;
    end else begin
      m_ready_q <= 1'b0;
      // A clear in the same cycle as a new error loses: error updates below override.
      if (err_clr_i) begin
        err_q       <= 1'b0;
        err_cause_q <= 2'b00;
      end
      case (state_q)
        ST_IDLE: begin
          // While m_ready is high the master still holds the finished
          // request. It must not be accepted a second time.
          if (m_valid_i && !m_ready_q) begin
            if (mapped_d) begin
              addr_q    <= m_addr_i;
              wdata_q   <= m_wdata_i;
              wstrb_q   <= m_wstrb_i;
              sel_q     <= sel_d;
              cnt_q     <= '0;
              s_valid_q <= onehot_d;
              state_q   <= ST_BUSY;
            end else begin
              state_q <= ST_ERR;
            end
          end
        end
        ST_BUSY: begin
          if (ready_sel_d) begin
            m_rdata_q <= rdata_sel_d;
            m_ready_q <= 1'b1;
            s_valid_q <= '0;
            state_q   <= ST_IDLE;
          end else if ((TIMEOUT != 0) && (cnt_q == TMO_LAST)) begin
            m_rdata_q   <= ERR_DATA;
            m_ready_q   <= 1'b1;
            s_valid_q   <= '0;
            err_q       <= 1'b1;
            err_cause_q <= CAUSE_TIMEOUT;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_ERR: begin
          m_rdata_q   <= ERR_DATA;
          m_ready_q   <= 1'b1;
          err_q       <= 1'b1;
          err_cause_q <= CAUSE_UNMAPPED;
          state_q     <= ST_IDLE;
        end
        default: begin
          s_valid_q <= '0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // Every lane carries the captured request. Only s_valid qualifies one lane.
  assign s_addr_o    = {N_SLAVES{addr_q}};
  assign s_wdata_o   = {N_SLAVES{wdata_q}};
  assign s_wstrb_o   = {N_SLAVES{wstrb_q}};
  assign s_valid_o   = s_valid_q;
  assign m_rdata_o   = m_rdata_q;
  assign m_ready_o   = m_ready_q;
  assign err_o       = err_q;
  assign err_cause_o = err_cause_q;

endmodule

// File: doc/iob_split_tmo.md
Name: iob_split_tmo

Overview:
- Parametrised successor of the native-bus splitter.
- Routes one IOb native master request to one of N_SLAVES slaves, selected by an address bit-field of configurable width and position.
- Adds registered request capture, per-transaction timeout, error response for unmapped selectors, and a sticky error status.
- Sits between the CPU data/peripheral bus and the peripheral slaves.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- N_SLAVES, 4, number of slave ports, 1..64.
- P_SLAVES, ADDR_W-2, MSB position of selector field.
- SEL_W, max(1,$clog2(N_SLAVES)), selector field width; field is m_addr[P_SLAVES -: SEL_W].
- TIMEOUT, 255, max BUSY cycles before abort; 0 disables timeout.
- ERR_DATA, 32'hDEADBEEF, rdata returned on error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- m_valid  in  1  master request; held high until m_ready.
- m_addr  in  ADDR_W  master address.
- m_wdata  in  DATA_W  write data.
- m_wstrb  in  DATA_W/8  byte strobes; 0 means read.
- m_rdata  out  DATA_W  read data, valid when m_ready.
- m_ready  out  1  transaction complete, one-cycle pulse.
- s_valid  out  N_SLAVES  one-hot slave request.
- s_addr  out  N_SLAVES*ADDR_W  per-slave address.
- s_wdata  out  N_SLAVES*DATA_W  per-slave write data.
- s_wstrb  out  N_SLAVES*DATA_W/8  per-slave strobes.
- s_rdata  in  N_SLAVES*DATA_W  per-slave read data.
- s_ready  in  N_SLAVES  per-slave completion.
- err  out  1  sticky error flag.
- err_cause  out  2  01 = unmapped, 10 = timeout, last error wins.
- err_clr  in  1  synchronous clear of err and err_cause.

Behaviour:
- Reset (rst low, asynchronous) sets state IDLE and forces these outputs to 0:
  - s_valid, m_ready, m_rdata, err, err_cause.
  - Captured addr/wdata/wstrb/sel registers.
  - Timeout counter.
- Reset mid-transaction drops s_valid immediately; no response is issued to the master.
- FSM states: IDLE, BUSY, ERR.
- IDLE, m_valid=1, sel<N_SLAVES:
  - Register addr, wdata, wstrb, sel.
  - Clear counter.
  - Go to BUSY.
- IDLE, m_valid=1, sel>=N_SLAVES: go to ERR.
- BUSY:
  - s_valid[sel]=1; all other s_valid bits are 0.
  - Registered addr/wdata/wstrb are driven on all slave lanes; only the selected lane is qualified.
  - s_ready[sel]=1 (may be in the same cycle s_valid rises): register m_rdata<=s_rdata[sel], m_ready<=1, go to IDLE.
  - s_ready on non-selected lanes is ignored.
- BUSY timeout:
  - Counter increments each BUSY cycle without s_ready[sel].
  - When counter==TIMEOUT-1 with no ready (TIMEOUT!=0): s_valid drops next cycle, m_rdata<=ERR_DATA, m_ready<=1, err<=1, err_cause<=10, go to IDLE.
  - A late s_ready from the aborted slave is ignored.
- ERR: one cycle; m_rdata<=ERR_DATA, m_ready<=1, err<=1, err_cause<=01, go to IDLE.
- m_ready is high exactly one cycle. The master must drop or replace m_valid in the following cycle; IDLE samples m_valid that cycle. Back-to-back transactions are allowed.
- m_rdata holds its value until the next completion.
- Latency, m_valid to m_ready:
  - Zero-wait slave: 2 cycles.
  - Slave with w wait cycles: 2+w cycles.
  - Unmapped: 2 cycles.
- Simultaneous error set and err_clr: set wins.
- err_clr alone clears err and err_cause in the next cycle.
- m_rdata is also updated on writes (slave rdata passed through); the master ignores it.
- N_SLAVES=1: SEL_W=1. sel=1 is unmapped unless P_SLAVES selection is disabled by the system map.

Test Plan:
- Read, N=4, P_SLAVES=31, m_addr=0x8000_0010, slave 2 ready in the same cycle as s_valid with rdata 0x1234_5678 -> s_valid=0100 for exactly 1 cycle; m_ready 2 cycles after m_valid; m_rdata=0x12345678; err=0.
- Write to slave 1 with 3 wait cycles, wstrb=4'b0011, wdata=0xA5A5_A5A5 -> s_wstrb/s_wdata on lane 1 match; m_ready at cycle 5; other lanes' s_valid stay 0.
- N=3, address selecting 3 -> no s_valid; m_ready at cycle 2; m_rdata=0xDEADBEEF; err=1; err_cause=01. Then err_clr=1 -> err=0 next cycle.
- TIMEOUT=8, slave 0 never ready -> s_valid[0] high 8 cycles then low; m_ready with ERR_DATA; err_cause=10. A late s_ready[0] produces no extra m_ready.
- Back-to-back reads to slaves 0 then 3, new m_valid in the cycle after m_ready -> second transaction completes correctly with no lost or duplicated m_ready.
- rst asserted low while in BUSY -> s_valid=0, m_ready=0, err=0 immediately (asynchronously). After release, the FSM is in IDLE and a new read completes normally.
